// File: rtl/bullet_table_pkg.sv
// Shared constants, slot record type and helpers for the bullet slot table.
package bullet_table_pkg;

  localparam int SLOT_COUNT = 8;
  localparam int SLOT_IDX_W = 3;
  localparam int X_W        = 10;
  localparam int Y_W        = 9;
  localparam int VX_W       = 4;
  localparam int COLOR_W    = 3;
  localparam int POS_W      = 11;
  localparam int COUNT_W    = SLOT_IDX_W + 1;

  localparam logic [COLOR_W-1:0] COLOR_DAMAGE      = 3'd0;
  localparam logic [COLOR_W-1:0] COLOR_HEAL        = 3'd1;
  localparam logic [COLOR_W-1:0] COLOR_MOVE_DAMAGE = 3'd2;

  typedef struct packed {
    logic                     active;
    logic [X_W-1:0]           x;
    logic [Y_W-1:0]           y;
    logic signed [VX_W-1:0]   vx;
    logic [COLOR_W-1:0]       color;
  } bullet_slot_t;

  function automatic logic [COUNT_W-1:0] popcount(input logic [SLOT_COUNT-1:0] m);
    logic [COUNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < SLOT_COUNT; i++) begin
      cnt = cnt + {{(COUNT_W-1){1'b0}}, m[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/bullet_table_if.sv
// Scanner query, player position, spawn/kill/move control and status of the bullet table.
interface bullet_table_if;
  import bullet_table_pkg::*;

  logic [SLOT_IDX_W-1:0] index;
  logic                  isRender;
  logic                  isCollide;
  logic [COLOR_W-1:0]    color;
  logic [X_W-1:0]        playerX;
  logic [Y_W-1:0]        playerY;
  logic                  freeze;
  logic                  scanDone;
  logic                  spawnValid;
  logic                  spawnReady;
  logic [X_W-1:0]        spawnX;
  logic [Y_W-1:0]        spawnY;
  logic [VX_W-1:0]       spawnVx;
  logic [COLOR_W-1:0]    spawnColor;
  logic                  killValid;
  logic [SLOT_IDX_W-1:0] killIndex;
  logic                  moveTick;
  logic [COUNT_W-1:0]    activeCount;

  modport master (
    output index, playerX, playerY, freeze, scanDone,
    output spawnValid, spawnX, spawnY, spawnVx, spawnColor,
    output killValid, killIndex, moveTick,
    input  isRender, isCollide, color, spawnReady, activeCount
  );

  modport slave (
    input  index, playerX, playerY, freeze, scanDone,
    input  spawnValid, spawnX, spawnY, spawnVx, spawnColor,
    input  killValid, killIndex, moveTick,
    output isRender, isCollide, color, spawnReady, activeCount
  );

endinterface

// File: rtl/bullet_hit_check.sv
// Combinational bullet/player overlap test on 11-bit signed centre differences.
module bullet_hit_check
  import bullet_table_pkg::*;
#(
  parameter int HIT_W = 16,
  parameter int HIT_H = 16
) (
  input  logic [X_W-1:0] bx,
  input  logic [Y_W-1:0] by,
  input  logic [X_W-1:0] px,
  input  logic [Y_W-1:0] py,
  output logic           hit
);

  localparam logic [POS_W-1:0] HALF_W = POS_W'(HIT_W);
  localparam logic [POS_W-1:0] HALF_H = POS_W'(HIT_H);

  function automatic logic [POS_W-1:0] abs_val(input logic signed [POS_W-1:0] d);
    return d[POS_W-1] ? POS_W'(-d) : POS_W'(d);
  endfunction

  logic signed [POS_W-1:0] dx;
  logic signed [POS_W-1:0] dy;

  assign dx  = $signed({1'b0, bx}) - $signed({1'b0, px});
  assign dy  = $signed({2'b00, by}) - $signed({2'b00, py});
  assign hit = (abs_val(dx) < HALF_W) && (abs_val(dy) < HALF_H);

endmodule

// File: rtl/bullet_table.sv
// Eight-slot bullet table: zero-latency scanner query plus spawn/kill/move held off while frozen.
// Optional macro BULLET_TABLE_HIT_CLEAR_EN clears bullets hit during a scan when scanDone pulses.
module bullet_table
  import bullet_table_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int HIT_W    = 16,
  parameter int HIT_H    = 16
) (
  input  logic           clk,
  input  logic           reset,
  bullet_table_if.slave  bus
);

  localparam logic signed [POS_W-1:0] X_MAX = POS_W'(SCREEN_W - 1);

  function automatic logic signed [POS_W-1:0] step_x(input logic [X_W-1:0] x,
                                                     input logic signed [VX_W-1:0] vx);
    logic signed [POS_W-1:0] vx_ext;
    vx_ext = $signed({{(POS_W-VX_W){vx[VX_W-1]}}, vx});
    return $signed({1'b0, x}) + vx_ext;
  endfunction

  function automatic logic on_screen(input logic signed [POS_W-1:0] nx);
    return !nx[POS_W-1] && (nx <= X_MAX);
  endfunction

  bullet_slot_t [SLOT_COUNT-1:0] slots;
  bullet_slot_t [SLOT_COUNT-1:0] slots_nxt;
  logic [SLOT_COUNT-1:0]         kill_pend;
  logic [SLOT_COUNT-1:0]         kill_pend_nxt;
  logic                          tick_pend;
  logic                          tick_pend_nxt;
  logic [COUNT_W-1:0]            count_q;

  logic [SLOT_COUNT-1:0]         active_mask;
  logic [SLOT_COUNT-1:0]         active_nxt;
  logic [SLOT_COUNT-1:0]         kill_req;
  logic [SLOT_COUNT-1:0]         kill_now;
  logic [SLOT_COUNT-1:0]         hit_done;
  logic [SLOT_COUNT-1:0]         query_onehot;
  logic                          tick_now;
  logic [SLOT_IDX_W-1:0]         spawn_slot;
  logic                          spawn_ready;
  logic                          spawn_fire;

  bullet_slot_t                  query;
  logic                          query_hit;
  logic                          collide;

  // Query path: purely combinational from the registered slot storage
  assign query = slots[bus.index];

  bullet_hit_check #(
    .HIT_W (HIT_W),
    .HIT_H (HIT_H)
  ) u_hit (
    .bx  (query.x),
    .by  (query.y),
    .px  (bus.playerX),
    .py  (bus.playerY),
    .hit (query_hit)
  );

  assign collide       = query.active && query_hit;
  assign bus.isRender  = query.active;
  assign bus.isCollide = collide;
  assign bus.color     = query.active ? query.color : '0;
  assign query_onehot  = SLOT_COUNT'(1) << bus.index;

  always_comb begin
    active_mask = '0;
    for (int i = 0; i < SLOT_COUNT; i++) begin
      active_mask[i] = slots[i].active;
    end
  end

  // Lowest-numbered free slot, judged on storage as it stood before this edge
  always_comb begin
    spawn_slot = '0;
    for (int i = SLOT_COUNT - 1; i >= 0; i--) begin
      if (!active_mask[i]) spawn_slot = SLOT_IDX_W'(i);
    end
  end

  assign spawn_ready    = !reset && !bus.freeze && (active_mask != '1);
  assign spawn_fire     = bus.spawnValid && spawn_ready;
  assign bus.spawnReady = spawn_ready;
  assign kill_req       = bus.killValid ? (SLOT_COUNT'(1) << bus.killIndex) : '0;

`ifdef BULLET_TABLE_HIT_CLEAR_EN
  logic [SLOT_COUNT-1:0] hit_mask;
  logic [SLOT_COUNT-1:0] hit_now;

  assign hit_now  = hit_mask | ((bus.freeze && collide) ? query_onehot : '0);
  assign hit_done = bus.scanDone ? hit_now : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_mask <= '0;
    end else begin
      hit_mask <= bus.scanDone ? '0 : hit_now;
    end
  end
`else
  logic [SLOT_COUNT+1-1:0] unused_scan;
  assign unused_scan = {bus.scanDone, query_onehot};
  assign hit_done    = '0;
`endif

  // Update order within one edge: kill, then move, then spawn into a pre-edge free slot
  always_comb begin
    logic signed [POS_W-1:0] nx;
    nx            = '0;
    slots_nxt     = slots;
    kill_now      = kill_pend | kill_req | hit_done;
    tick_now      = tick_pend | bus.moveTick;
    kill_pend_nxt = '0;
    tick_pend_nxt = 1'b0;
    if (bus.freeze) begin
      kill_pend_nxt = kill_now;
      tick_pend_nxt = tick_now;
    end else begin
      for (int i = 0; i < SLOT_COUNT; i++) begin
        if (kill_now[i]) begin
          slots_nxt[i] = '0;
        end else if (tick_now && slots[i].active) begin
          nx = step_x(slots[i].x, slots[i].vx);
          if (on_screen(nx)) begin
            slots_nxt[i].x = nx[X_W-1:0];
          end else begin
            slots_nxt[i] = '0;
          end
        end
      end
      if (spawn_fire) begin
        slots_nxt[spawn_slot] = '{active: 1'b1,
                                  x:      bus.spawnX,
                                  y:      bus.spawnY,
                                  vx:     $signed(bus.spawnVx),
                                  color:  bus.spawnColor};
      end
    end
  end

  always_comb begin
    active_nxt = '0;
    for (int i = 0; i < SLOT_COUNT; i++) begin
      active_nxt[i] = slots_nxt[i].active;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slots     <= '0;
      kill_pend <= '0;
      tick_pend <= 1'b0;
      count_q   <= '0;
    end else begin
      slots     <= slots_nxt;
      kill_pend <= kill_pend_nxt;
      tick_pend <= tick_pend_nxt;
      count_q   <= popcount(active_nxt);
    end
  end

  assign bus.activeCount = count_q;

endmodule
